// File: rtl/meas_seq_pkg.sv
// Shared types and constants for the demod-chain measurement sequencer.
// State encoding, modulation one-hot codes and the timer width.
package meas_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DETECT  = 3'd3,
    ST_AFAIL   = 3'd4,
    ST_LOCK    = 3'd5,
    ST_RUN     = 3'd6,
    ST_FAIL    = 3'd7
  } state_t;

  localparam logic [2:0] MOD_NONE = 3'b000;
  localparam logic [2:0] MOD_AM   = 3'b001;
  localparam logic [2:0] MOD_FM   = 3'b010;
  localparam logic [2:0] MOD_PSK  = 3'b100;

  localparam int TMR_W = 26;

  function automatic logic is_onehot(input logic [2:0] t);
    return (t == MOD_AM) || (t == MOD_FM) || (t == MOD_PSK);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter for the sequencer dwell/timeout timing.
// Holds at zero once expired; a load always takes priority.
module seq_timer
  import meas_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             expired
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/meas_sequencer.sv
// Measurement sequencer: settle, FFT capture, detect, lock, with retries.
// Optional MEAS_AUTO_REMEAS_EN: RUN re-measures after REMEAS_CYC cycles.
module meas_sequencer
  import meas_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = 1024,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int RETRY_MAX   = 3,
  parameter int REMEAS_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       wr_done,
  input  logic       det_valid,
  input  logic [2:0] det_type,
  input  logic       det_mode,
  output logic       fft_en,
  output logic       cap_rst_n,
  output logic       det_en,
  output logic       fast_clk_sel,
  output logic [2:0] mod_type,
  output logic       mode,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] retry_cnt
);

  // Loads are N-1 so that a state lasts exactly N cycles.
  localparam logic [TMR_W-1:0] LD_SETTLE  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] LD_TIMEOUT = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] LD_REMEAS  = TMR_W'(REMEAS_CYC - 1);
  localparam logic [1:0]       RETRY_LIM  = 2'(RETRY_MAX);

  state_t           state;
  state_t           nxt;
  logic             wr_q;
  logic             wr_rise;
  logic             expired;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;

  assign wr_rise  = wr_done & ~wr_q;
  assign tmr_load = (nxt != state);

  always_comb begin
    nxt = state;
    if (abort) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (start) nxt = ST_SETTLE;
        ST_SETTLE:  if (expired) nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          if (wr_rise) nxt = ST_DETECT;
          else if (expired) nxt = ST_AFAIL;
        end
        ST_DETECT: begin
          if (det_valid)
            nxt = is_onehot(det_type) ? ST_LOCK : ST_AFAIL;
          else if (expired)
            nxt = ST_AFAIL;
        end
        ST_AFAIL:
          nxt = (retry_cnt < RETRY_LIM) ? ST_SETTLE : ST_FAIL;
        ST_LOCK:    nxt = ST_RUN;
        ST_RUN: begin
          if (start) nxt = ST_SETTLE;
`ifdef MEAS_AUTO_REMEAS_EN
          else if (expired) nxt = ST_SETTLE;
`endif
        end
        ST_FAIL:    if (start) nxt = ST_SETTLE;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tmr_val = '0;
    unique case (nxt)
      ST_SETTLE:  tmr_val = LD_SETTLE;
      ST_CAPTURE: tmr_val = LD_TIMEOUT;
      ST_DETECT:  tmr_val = LD_TIMEOUT;
      ST_RUN:     tmr_val = LD_REMEAS;
      default:    tmr_val = '0;
    endcase
  end

  seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wr_q         <= 1'b0;
      fft_en       <= 1'b0;
      cap_rst_n    <= 1'b0;
      det_en       <= 1'b0;
      fast_clk_sel <= 1'b0;
      mod_type     <= MOD_NONE;
      mode         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      retry_cnt    <= 2'd0;
    end else begin
      state <= nxt;
      // Arm high during SETTLE so a level already up at capture start is ignored.
      wr_q  <= (state == ST_SETTLE) ? 1'b1 : wr_done;
      busy  <= (nxt == ST_SETTLE) || (nxt == ST_CAPTURE)
            || (nxt == ST_DETECT);
      done  <= (nxt == ST_RUN) && (state != ST_RUN);
      err   <= (nxt == ST_FAIL);
      unique case (nxt)
        ST_IDLE: begin
          fft_en       <= 1'b0;
          cap_rst_n    <= 1'b0;
          det_en       <= 1'b0;
          fast_clk_sel <= 1'b0;
          mod_type     <= MOD_NONE;
          mode         <= 1'b0;
          retry_cnt    <= 2'd0;
        end
        ST_SETTLE: begin
          fft_en       <= 1'b0;
          cap_rst_n    <= 1'b0;
          det_en       <= 1'b0;
          fast_clk_sel <= 1'b0;
          if (state == ST_IDLE || state == ST_RUN || state == ST_FAIL)
            retry_cnt <= 2'd0;
        end
        ST_CAPTURE: begin
          fft_en    <= 1'b1;
          cap_rst_n <= 1'b1;
          det_en    <= 1'b0;
        end
        ST_DETECT: begin
          fft_en <= 1'b0;
          det_en <= 1'b1;
        end
        ST_AFAIL: begin
          fft_en    <= 1'b0;
          cap_rst_n <= 1'b0;
          det_en    <= 1'b0;
          retry_cnt <= retry_cnt + 2'd1;
        end
        ST_LOCK: begin
          mod_type     <= det_type;
          mode         <= det_mode;
          fast_clk_sel <= 1'b1;
          det_en       <= 1'b0;
        end
        ST_RUN: begin
        end
        ST_FAIL: begin
          fft_en       <= 1'b0;
          cap_rst_n    <= 1'b0;
          det_en       <= 1'b0;
          fast_clk_sel <= 1'b0;
          mod_type     <= MOD_NONE;
          mode         <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// Scoreboard bench for meas_sequencer with a per-measurement outcome model.
// Optional MEAS_AUTO_REMEAS_EN adds the auto re-measure scenario.
module tb_meas_sequencer;

  localparam int S  = 16;
  localparam int T  = 200;
  localparam int R  = 3;
  localparam int RM = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       wr_done = 1'b0;
  logic       det_valid = 1'b0;
  logic [2:0] det_type = 3'b000;
  logic       det_mode = 1'b0;
  logic       fft_en;
  logic       cap_rst_n;
  logic       det_en;
  logic       fast_clk_sel;
  logic [2:0] mod_type;
  logic       mode;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] retry_cnt;

  meas_sequencer #(
    .SETTLE_CYC  (S),
    .TIMEOUT_CYC (T),
    .RETRY_MAX   (R),
    .REMEAS_CYC  (RM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .wr_done      (wr_done),
    .det_valid    (det_valid),
    .det_type     (det_type),
    .det_mode     (det_mode),
    .fft_en       (fft_en),
    .cap_rst_n    (cap_rst_n),
    .det_en       (det_en),
    .fast_clk_sel (fast_clk_sel),
    .mod_type     (mod_type),
    .mode         (mode),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .retry_cnt    (retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         fail;
    logic [2:0] mt;
    logic       md;
    logic [1:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // attempt kinds: 0 capture timeout, 1 bad type, 2 detect timeout,
  // 3 good lock, 4 wr_done high before capture (ignored -> timeout)
  int         plan_k[R];
  logic [2:0] plan_t[R];
  logic       plan_m[R];
  logic [2:0] cur_mt = 3'b000;
  logic       cur_md = 1'b0;

  logic [2:0] good_tbl[3] = '{3'b001, 3'b010, 3'b100};
  logic [2:0] bad_tbl[5]  = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [13:0] outs();
    return {fft_en, cap_rst_n, det_en, fast_clk_sel, mod_type, mode,
            busy, done, err, retry_cnt};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Scoreboard monitor: pops one expectation per done pulse or err rise.
  logic err_q = 1'b0;
  logic done_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [8:0] act;
    logic [8:0] expv;
    if (rst_n) begin
      if (done || (err && !err_q)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got done=%0b err=%0b expected none",
                   done, err);
        end else begin
          e = exp_q.pop_front();
          act  = {err, mod_type, mode, retry_cnt, fast_clk_sel, busy};
          expv = {e.fail, e.mt, e.md, e.rc, ~e.fail, 1'b0};
          chk("result", int'(act), int'(expv));
        end
      end
      if (done) chk("done_single", int'(done_q), 0);
    end
    err_q  <= err;
    done_q <= done;
  end

  task automatic do_attempt(input int kind, input logic [2:0] ty,
                            input logic md, input bit first,
                            input int cap_delay);
    int n;
    int m;
    int d;
    if (kind == 4) wr_done = 1'b1;
    n = 0;
    while (!fft_en && n < S + 20) begin
      step();
      n++;
    end
    if (first) chk("settle_len", n, S);
    else chk("capture_entry", int'(fft_en), 1);
    if (kind == 0 || kind == 4) begin
      m = 0;
      while (fft_en && m < T + 20) begin
        m++;
        step();
      end
      chk("capture_timeout_len", m, T);
      wr_done = 1'b0;
    end else begin
      d = (cap_delay > 0) ? cap_delay : int'($urandom_range(1, 20));
      for (int i = 0; i < d; i++) begin
        if (kind == 3 && i == 0) start = 1'b1;
        step();
        start = 1'b0;
      end
      wr_done = 1'b1;
      n = 0;
      while (!det_en && n < 5) begin
        step();
        n++;
      end
      chk("detect_entry", int'(det_en), 1);
      wr_done = 1'b0;
      if (kind == 2) begin
        m = 0;
        while (det_en && m < T + 20) begin
          m++;
          step();
        end
        chk("detect_timeout_len", m, T);
      end else begin
        repeat ($urandom_range(0, 15)) step();
        det_valid = 1'b1;
        det_type  = ty;
        det_mode  = md;
        step();
        det_valid = 1'b0;
        det_type  = 3'($urandom_range(0, 7));
        det_mode  = 1'b0;
      end
    end
  endtask

  task automatic run_meas(input bit do_start, input int cap_delay);
    exp_t e;
    int   win;
    int   n;
    win = -1;
    for (int a = 0; a < R; a++)
      if (win < 0 && plan_k[a] == 3) win = a;
    if (win >= 0) begin
      e.fail = 1'b0;
      e.mt   = plan_t[win];
      e.md   = plan_m[win];
      e.rc   = 2'(win);
    end else begin
      e.fail = 1'b1;
      e.mt   = 3'b000;
      e.md   = 1'b0;
      e.rc   = 2'(R);
    end
    exp_q.push_back(e);
    if (do_start) pulse_start();
    chk("settle_outs", int'({mod_type, mode, fast_clk_sel, busy}),
        int'({cur_mt, cur_md, 1'b0, 1'b1}));
    for (int a = 0; a < R; a++) begin
      do_attempt(plan_k[a], plan_t[a], plan_m[a], a == 0, cap_delay);
      if (plan_k[a] == 3) break;
    end
    n = 0;
    while (!(done || err) && n < 10) begin
      step();
      n++;
    end
    chk("terminal_seen", int'(done || err), 1);
    cur_mt = e.mt;
    cur_md = e.md;
    step();
    step();
  endtask

  task automatic set_plan(input int k0, input int k1, input int k2,
                          input logic [2:0] t0, input logic [2:0] t1,
                          input logic [2:0] t2);
    plan_k[0] = k0;
    plan_k[1] = k1;
    plan_k[2] = k2;
    plan_t[0] = t0;
    plan_t[1] = t1;
    plan_t[2] = t2;
    for (int a = 0; a < R; a++) plan_m[a] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("reset_outs", int'(outs()), 0);
    rst_n = 1'b1;
    step();
    chk("idle_outs", int'(outs()), 0);

    set_plan(3, 0, 0, 3'b010, 3'b000, 3'b000);
    run_meas(1'b1, 100);

    set_plan(0, 0, 0, 3'b000, 3'b000, 3'b000);
    run_meas(1'b1, 0);

    set_plan(1, 1, 3, 3'b011, 3'b011, 3'b100);
    run_meas(1'b1, 0);

    // abort and start together during DETECT
    pulse_start();
    n = 0;
    while (!fft_en && n < S + 20) begin
      step();
      n++;
    end
    repeat (3) step();
    wr_done = 1'b1;
    n = 0;
    while (!det_en && n < 5) begin
      step();
      n++;
    end
    wr_done = 1'b0;
    chk("abort_pre_detect", int'(det_en), 1);
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_idle", int'(outs()), 0);
    repeat (3) step();
    chk("abort_beats_start", int'(outs()), 0);
    cur_mt = 3'b000;
    cur_md = 1'b0;

    // asynchronous reset in the middle of CAPTURE
    pulse_start();
    n = 0;
    while (!fft_en && n < S + 20) begin
      step();
      n++;
    end
    chk("rst_pre_capture", int'(fft_en), 1);
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", int'(outs()), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    set_plan(3, 0, 0, 3'b001, 3'b000, 3'b000);
    run_meas(1'b1, 0);

    set_plan(4, 2, 3, 3'b000, 3'b000, 3'b100);
    run_meas(1'b1, 0);

    // abort out of RUN clears the latched type
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_run", int'(outs()), 0);
    cur_mt = 3'b000;
    cur_md = 1'b0;

    for (int it = 0; it < 14; it++) begin
      for (int a = 0; a < R; a++) begin
        plan_k[a] = int'($urandom_range(0, 4));
        if ($urandom_range(0, 1) == 1) plan_k[a] = 3;
        plan_m[a] = 1'($urandom_range(0, 1));
        if (plan_k[a] == 3) plan_t[a] = good_tbl[$urandom_range(0, 2)];
        else plan_t[a] = bad_tbl[$urandom_range(0, 4)];
      end
      run_meas(1'b1, 0);
      repeat ($urandom_range(0, 5)) step();
    end

`ifdef MEAS_AUTO_REMEAS_EN
    set_plan(3, 0, 0, 3'b010, 3'b000, 3'b000);
    run_meas(1'b1, 0);
    n = 2;
    while (!busy && n < RM + 50) begin
      step();
      n++;
    end
    chk("remeas_dwell", n, RM);
    set_plan(1, 3, 0, 3'b000, 3'b100, 3'b000);
    run_meas(1'b0, 0);
`endif

    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
